// File: rtl/binary_frame_buffer_if.sv
// ---------------------------------------------------------------------------
// binary_frame_buffer_if
// Bundle of the capture stream, frame handshake and row-read port of the
// binary frame buffer.
//   master : preprocessor + classifier side (drives pixels, ack, rd_row)
//   slave  : the frame buffer itself
// Signals:
//   binary_pixel/binary_valid : serial binarised pixel stream, raster order
//   frame_done                : end-of-frame pulse from the preprocessor
//   frame_vsync               : frame sync, rising edge starts a new frame
//   frame_ready/frame_ack     : frame published / consumer releases it
//   rd_row/rd_row_data        : registered row-word read port
//   frames_published/dropped  : wrapping 8-bit event counters
// ---------------------------------------------------------------------------
interface binary_frame_buffer_if #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
);
  logic             binary_pixel;
  logic             binary_valid;
  logic             frame_done;
  logic             frame_vsync;
  logic             frame_ready;
  logic             frame_ack;
  logic [4:0]       rd_row;
  logic [IMG_W-1:0] rd_row_data;
  logic [7:0]       frames_published;
  logic [7:0]       frames_dropped;

  modport master (
    output binary_pixel, binary_valid, frame_done, frame_vsync, frame_ack, rd_row,
    input  frame_ready, rd_row_data, frames_published, frames_dropped
  );

  modport slave (
    input  binary_pixel, binary_valid, frame_done, frame_vsync, frame_ack, rd_row,
    output frame_ready, rd_row_data, frames_published, frames_dropped
  );
endinterface

// File: rtl/binary_frame_buffer.sv
// ---------------------------------------------------------------------------
// binary_frame_buffer
// Double-buffered store for one IMG_H x IMG_W binary image. Pixels are packed
// into row words in the capture bank; a completed frame is handed to the
// consumer by swapping banks, so capture of the next frame can proceed while
// the consumer reads the previous one.
// Ports:
//   pixel_clk : pipeline clock, rising edge
//   rst       : asynchronous active-high reset
//   bus       : binary_frame_buffer_if.slave (stream, handshake, read port)
// ---------------------------------------------------------------------------
module binary_frame_buffer #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                  pixel_clk,
  input  logic                  rst,
  binary_frame_buffer_if.slave  bus
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

  typedef enum logic {W_FILL, W_FULL}  w_state_t;
  typedef enum logic {R_EMPTY, R_HELD} r_state_t;

  w_state_t         w_state, w_next;
  r_state_t         r_state, r_next;
  logic             wr_bank;
  logic             vsync_p1;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [7:0]       published, dropped;

  logic [IMG_W-1:0] row_word;
  logic [IMG_W-1:0] word_full;
  logic [IMG_W-1:0] mem [2][IMG_H];
  logic [IMG_W-1:0] rd_data_p1;

  logic vsync_rise, accept, row_end, frame_end, short_frame, overrun, swap;

  assign vsync_rise = bus.frame_vsync & ~vsync_p1;

  // Next-state and control decode. Swap and ack both look at registered
  // states, which guarantees a ready-low cycle between consecutive frames.
  always_comb begin
    w_next      = w_state;
    r_next      = r_state;
    accept      = 1'b0;
    row_end     = 1'b0;
    frame_end   = 1'b0;
    short_frame = 1'b0;
    overrun     = 1'b0;
    swap        = 1'b0;
    word_full   = row_word;
    word_full[col] = bus.binary_pixel;

    case (w_state)
      W_FILL: begin
        accept    = bus.binary_valid;
        row_end   = accept && (col == LAST_COL);
        frame_end = row_end && (row == LAST_ROW);
        if (frame_end) begin
          w_next = W_FULL;
        end else if ((bus.frame_done || vsync_rise) && (row != '0 || col != '0)) begin
          // Truncated frame: the pixel arriving with the event is discarded too.
          short_frame = 1'b1;
          accept      = 1'b0;
          row_end     = 1'b0;
        end
      end
      W_FULL: begin
        overrun = bus.frame_done;
        if (r_state == R_EMPTY) begin
          swap   = 1'b1;
          w_next = W_FILL;
        end
      end
      default: w_next = W_FILL;
    endcase

    case (r_state)
      R_EMPTY: if (swap)          r_next = R_HELD;
      R_HELD:  if (bus.frame_ack) r_next = R_EMPTY;
      default: r_next = R_EMPTY;
    endcase
  end

  // Control state, counters and bank select
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      w_state   <= W_FILL;
      r_state   <= R_EMPTY;
      wr_bank   <= 1'b0;
      vsync_p1  <= 1'b0;
      col       <= '0;
      row       <= '0;
      published <= '0;
      dropped   <= '0;
    end else begin
      w_state  <= w_next;
      r_state  <= r_next;
      vsync_p1 <= bus.frame_vsync;
      if (swap) begin
        wr_bank   <= ~wr_bank;
        col       <= '0;
        row       <= '0;
        published <= published + 8'd1;
      end else if (short_frame) begin
        col <= '0;
        row <= '0;
      end else if (accept) begin
        if (row_end) begin
          col <= '0;
          row <= frame_end ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (short_frame || overrun) dropped <= dropped + 8'd1;
    end
  end

  // Capture datapath: pixel packing and row write into the capture bank
  always_ff @(posedge pixel_clk) begin
    if (accept) row_word[col] <= bus.binary_pixel;
    if (row_end) mem[wr_bank][row] <= word_full;
  end

  // Read stage p1: registered row word from the consumer bank
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      rd_data_p1 <= '0;
    end else if (bus.rd_row <= LAST_ROW) begin
      rd_data_p1 <= mem[~wr_bank][bus.rd_row];
    end else begin
      rd_data_p1 <= '0;
    end
  end

  assign bus.frame_ready      = (r_state == R_HELD);
  assign bus.rd_row_data      = rd_data_p1;
  assign bus.frames_published = published;
  assign bus.frames_dropped   = dropped;
endmodule

// File: tb/tb_binary_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_binary_frame_buffer
// Drives directed and randomised pixel streams, handshakes and row reads into
// binary_frame_buffer and compares every cycle against a pixel-level
// reference model of the two image banks and the publish/ack protocol.
// ---------------------------------------------------------------------------
module tb_binary_frame_buffer;
  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int NPIX  = IMG_W * IMG_H;

  logic pixel_clk = 1'b0;
  logic rst       = 1'b0;

  binary_frame_buffer_if #(.IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();

  binary_frame_buffer #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 pixel_clk = ~pixel_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: images as pixel arrays, frame states as plain flags
  bit         img [2][IMG_H][IMG_W];
  bit         img_ok [2];
  int         m_cnt;
  bit         m_full, m_held, m_wb, m_vs;
  logic [7:0] m_pub, m_drop;
  logic [IMG_W-1:0] m_rd;
  bit         m_rd_chk;

  task automatic model_reset();
    m_cnt = 0; m_full = 0; m_held = 0; m_wb = 0; m_vs = 0;
    m_pub = '0; m_drop = '0; m_rd = '0; m_rd_chk = 1;
  endtask

  task automatic model_clock(input bit pix, input bit valid, input bit done,
                             input bit vs, input bit ack, input int rr);
    bit vr, rdb, held_old;
    vr = vs && !m_vs;
    m_vs = vs;
    rdb = !m_wb;
    held_old = m_held;
    if (rr < IMG_H) begin
      m_rd_chk = img_ok[rdb];
      for (int c = 0; c < IMG_W; c++) m_rd[c] = img[rdb][rr][c];
    end else begin
      m_rd = '0;
      m_rd_chk = 1;
    end
    if (!m_full) begin
      if (valid && m_cnt == NPIX - 1) begin
        img[m_wb][IMG_H-1][IMG_W-1] = pix;
        img_ok[m_wb] = 1;
        m_full = 1;
        m_cnt = 0;
      end else if ((done || vr) && m_cnt != 0) begin
        m_drop++;
        m_cnt = 0;
      end else if (valid) begin
        img_ok[m_wb] = 0;
        img[m_wb][m_cnt / IMG_W][m_cnt % IMG_W] = pix;
        m_cnt++;
      end
    end else begin
      if (done) m_drop++;
      if (!held_old) begin
        m_wb = !m_wb;
        m_pub++;
        m_full = 0;
        m_held = 1;
      end
    end
    if (held_old && ack) m_held = 0;
  endtask

  function automatic int rnd_row();
    return int'($urandom_range(0, 31));
  endfunction

  // One clock: drive, let the model see the same edge, check at negedge
  task automatic cyc(input bit pix, input bit valid, input bit done,
                     input bit vs, input bit ack, input int rr);
    bus.binary_pixel = pix;
    bus.binary_valid = valid;
    bus.frame_done   = done;
    bus.frame_vsync  = vs;
    bus.frame_ack    = ack;
    bus.rd_row       = 5'(rr);
    @(posedge pixel_clk);
    model_clock(pix, valid, done, vs, ack, rr);
    @(negedge pixel_clk);
    check_val("frame_ready", 32'(bus.frame_ready), 32'(m_held));
    check_val("frames_published", 32'(bus.frames_published), 32'(m_pub));
    check_val("frames_dropped", 32'(bus.frames_dropped), 32'(m_drop));
    if (m_rd_chk) check_val("rd_row_data", 32'(bus.rd_row_data), 32'(m_rd));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, rnd_row());
  endtask

  // mode 0: checkerboard (row^col), 1: all ones, 2: random
  task automatic send_pixels(input int n, input int mode, input int max_gap, input bit done_last);
    for (int k = 0; k < n; k++) begin
      int g;
      bit p;
      g = int'($urandom_range(0, max_gap));
      for (int i = 0; i < g; i++) cyc(0, 0, 0, 0, 0, rnd_row());
      case (mode)
        0:       p = bit'(((k / IMG_W) + (k % IMG_W)) & 1);
        1:       p = 1'b1;
        default: p = bit'($urandom_range(0, 1));
      endcase
      cyc(p, 1, done_last && (k == n - 1), 0, 0, rnd_row());
    end
  endtask

  task automatic read_expect(input string tag, input int r, input logic [31:0] exp);
    cyc(0, 0, 0, 0, 0, r);
    check_val(tag, 32'(bus.rd_row_data), exp);
  endtask

  task automatic ack_pulse();
    cyc(0, 0, 0, 0, 1, rnd_row());
  endtask

  task automatic do_reset(input int hold);
    #2 rst = 1'b1;
    bus.binary_valid = 0; bus.frame_done = 0; bus.frame_vsync = 0; bus.frame_ack = 0;
    #1;
    check_val("rst_frame_ready", 32'(bus.frame_ready), 32'd0);
    check_val("rst_rd_row_data", 32'(bus.rd_row_data), 32'd0);
    check_val("rst_published", 32'(bus.frames_published), 32'd0);
    check_val("rst_dropped", 32'(bus.frames_dropped), 32'd0);
    model_reset();
    for (int i = 0; i < hold; i++) @(posedge pixel_clk);
    @(negedge pixel_clk);
    rst = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.binary_pixel = 0; bus.binary_valid = 0; bus.frame_done = 0;
    bus.frame_vsync = 0; bus.frame_ack = 0; bus.rd_row = '0;
    for (int b = 0; b < 2; b++) img_ok[b] = 0;
    model_reset();
    @(negedge pixel_clk);
    do_reset(2);

    // Checkerboard frame, continuous valid, done on the last pixel
    send_pixels(NPIX, 0, 0, 1);
    check_val("lat_t1_ready", 32'(bus.frame_ready), 32'd0);
    idle(1);
    check_val("lat_t2_ready", 32'(bus.frame_ready), 32'd1);
    read_expect("chk_row0", 0, 32'h0AAAAAAA);
    read_expect("chk_row1", 1, 32'h05555555);
    check_val("f1_published", 32'(bus.frames_published), 32'd1);
    check_val("f1_dropped", 32'(bus.frames_dropped), 32'd0);

    // All-ones frame, bursty, captured while the first is still held
    send_pixels(NPIX, 1, 3, 1);
    read_expect("held_row0", 0, 32'h0AAAAAAA);
    read_expect("held_row27", 27, 32'h05555555);
    // Third frame while a full bank is pending: its done is an overrun
    send_pixels(NPIX, 2, 0, 1);
    check_val("overrun_dropped", 32'(bus.frames_dropped), 32'd1);
    ack_pulse();
    check_val("ack_ready_low", 32'(bus.frame_ready), 32'd0);
    idle(1);
    check_val("ack_ready_high", 32'(bus.frame_ready), 32'd1);
    for (int r = 0; r < 32; r++)
      read_expect("ones_row", r, (r < IMG_H) ? 32'h0FFFFFFF : 32'd0);
    ack_pulse();
    ack_pulse();  // ack while empty is ignored

    // Short frame then a full checkerboard frame from row 0 col 0
    send_pixels(500, 2, 1, 0);
    cyc(0, 0, 1, 0, 0, rnd_row());
    check_val("short_dropped", 32'(bus.frames_dropped), 32'd2);
    idle(3);
    check_val("short_no_ready", 32'(bus.frame_ready), 32'd0);
    send_pixels(NPIX, 0, 1, 0);
    idle(2);
    read_expect("after_short_row0", 0, 32'h0AAAAAAA);
    read_expect("after_short_row1", 1, 32'h05555555);
    check_val("after_short_pub", 32'(bus.frames_published), 32'd3);
    ack_pulse();

    // vsync edge after 100 pixels discards the partial frame
    send_pixels(100, 2, 0, 0);
    cyc(0, 0, 0, 1, 0, rnd_row());
    cyc(0, 0, 0, 1, 0, rnd_row());
    cyc(0, 0, 0, 0, 0, rnd_row());
    check_val("vsync_dropped", 32'(bus.frames_dropped), 32'd3);
    send_pixels(NPIX, 2, 2, 1);
    idle(2);
    for (int r = 0; r < IMG_H; r++) cyc(0, 0, 0, 0, 0, r);
    ack_pulse();

    // Reset mid-capture, then mid-hold
    send_pixels(300, 2, 1, 0);
    do_reset(1);
    send_pixels(NPIX, 2, 0, 1);
    idle(3);
    do_reset(2);
    send_pixels(NPIX, 0, 0, 1);
    idle(2);
    check_val("post_rst_pub", 32'(bus.frames_published), 32'd1);
    check_val("post_rst_drop", 32'(bus.frames_dropped), 32'd0);
    read_expect("post_rst_row1", 1, 32'h05555555);

    // Random mix of frame lengths, gaps, syncs and acks
    for (int f = 0; f < 8; f++) begin
      int n;
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NPIX - 1)) : NPIX;
      send_pixels(n, 2, 2, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        cyc(0, 0, 0, 1, 0, rnd_row());
        cyc(0, 0, 0, 0, 0, rnd_row());
      end
      for (int i = 0; i < 40; i++)
        cyc(0, 0, bit'($urandom_range(0, 15) == 0), 0, bit'($urandom_range(0, 7) == 0), rnd_row());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/binary_frame_buffer.md
# binary_frame_buffer

Double-buffered capture store for the 28×28 binary image produced by the image preprocessing pipeline. It packs the serial `binary_pixel`/`binary_valid` stream into row words. It publishes each complete frame to the digit classifier through a ready/ack handshake and a registered row-read port. A new frame can be captured while the classifier is still reading the previous one.

## Interface
- `IMG_W`, 28, pixels per row (row word width)
- `IMG_H`, 28, rows per frame
- `pixel_clk`  in  1  pipeline clock (65 MHz), all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `binary_pixel`  in  1  binarised pixel, raster order (row 0 col 0 first)
- `binary_valid`  in  1  `binary_pixel` valid this cycle
- `frame_done`  in  1  single-cycle end-of-frame pulse from the preprocessor
- `frame_vsync`  in  1  camera/DDR frame sync; its rising edge marks a new input frame
- `frame_ready`  out  1  a complete frame is held in the read bank
- `frame_ack`  in  1  single-cycle pulse from the consumer releasing the read bank
- `rd_row`  in  5  row index to read (0..IMG_H-1)
- `rd_row_data`  out  IMG_W  row word; bit c = pixel at column c
- `frames_published`  out  8  wrapping count of frames made ready
- `frames_dropped`  out  8  wrapping count of discarded frames (short or overrun)

## Operation
- Storage is two banks of IMG_H words × IMG_W bits. `wr_bank` selects the capture bank and `rd_bank` = ~`wr_bank` is the bank the consumer reads.
- Capture counters: `col` (0..IMG_W-1) and `row` (0..IMG_H-1). Each valid pixel shifts into bit `col` of a row register.
  - When `col`=IMG_W-1, the completed word, including the current pixel, is written to `wr_bank[row]`, `col` clears and `row` increments.
- Write FSM:
  - W_FILL (reset state): accepts pixels.
    - The valid pixel with `row`=IMG_H-1 and `col`=IMG_W-1 completes the frame, and the FSM goes to W_FULL.
    - `frame_done`, or a `frame_vsync` rising edge, while in W_FILL with a pixel count other than 0 means a short frame: counters clear, `frames_dropped`+1, and the FSM stays in W_FILL.
    - If `frame_done` arrives in the same cycle as the completing pixel, it does not count as a short frame.
  - W_FULL: all incoming pixels are ignored, and each `frame_done` received increments `frames_dropped` (overrun).
    - When the read FSM is R_EMPTY (registered state), the block toggles `wr_bank`, clears the counters, increments `frames_published`, and moves to W_FILL; the read FSM moves to R_HELD.
- Read FSM:
  - R_EMPTY (reset state): `frame_ready`=0.
  - R_HELD: `frame_ready`=1. `frame_ack` moves the FSM to R_EMPTY.
  - `frame_ack` while in R_EMPTY is ignored.
- Ack and swap are evaluated in the same cycle from registered states, so `frame_ready` is always low for at least one cycle between consecutive frames.
- `rd_row_data` returns `rd_bank[rd_row]`, registered. An out-of-range `rd_row` (28..31) returns 0.
- Counters wrap modulo 256.
- Pixels after the 784th and before the next swap are dropped silently; only `frame_done` drives `frames_dropped`.

## Timing
- Reset values: `frame_ready`=0, `rd_row_data`=0, `frames_published`=0, `frames_dropped`=0, `wr_bank`=0, `col`=`row`=0, W_FILL, R_EMPTY. Memory contents are not reset.
- Completing pixel at cycle t with reader R_EMPTY: W_FULL at t+1, swap at t+1, `frame_ready`=1 at t+2.
- `frame_ack` at t: `frame_ready`=0 at t+1. If a full bank is pending, `frame_ready`=1 again at t+2 with the new bank.
- Read latency: `rd_row` sampled at t, data valid at t+1. Data is stable for the whole R_HELD interval, because capture never writes `rd_bank`.
- Pixels may arrive every cycle, with no throughput limit in W_FILL.
- `frame_vsync` edge detection uses one registered delay, so an edge at input cycle t acts at t+1. It has no effect in W_FULL.
- Reset asserted mid-frame: everything returns to reset values immediately. The partial frame is lost and not counted.

## Test plan
- Single frame, checkerboard (pixel = row^col), valid every cycle, `frame_done` on the last pixel → `frame_ready`=1 two cycles after the last pixel, row 0 reads 0xAAAAAAA, row 1 reads 0x5555555, `frames_published`=1, `frames_dropped`=0.
- Bursty input with 0–3 idle cycles between valids, all-ones frame → every row reads 0xFFFFFFF, rows 28–31 read 0.
- Second frame arrives while the first is unacked → both banks stay intact; the first frame still reads correctly. A third frame's `frame_done` gives `frames_dropped`=1. `frame_ack` → `frame_ready` 0 for one cycle, then 1 with second-frame data.
- Short frame: 500 pixels then `frame_done` → `frames_dropped`=1, `frame_ready` stays 0. A following full frame captures correctly from row 0 col 0.
- `frame_vsync` rising edge after 100 pixels → partial frame discarded (`frames_dropped`+1), and the next 784 pixels form a correct frame.
- Reset asserted mid-capture and mid-hold → all outputs 0 within the reset cycle, and the next full frame publishes with `frames_published`=1.
